uart_tx_sched: RTL and testbench
================================

// Module: uart_tx_sched
// PURPOSE
// Round-robin, packet-locked scheduler sharing one uart_tx instance among N_REQ byte sources (status, IQ telemetry, debug).
// Accepts one byte at a time from the granted requester and drives i_Tx_DV/i_Tx_Byte of uart_tx.
// Sequences each byte against o_Tx_Active/o_Tx_Done. uart_tx runs on osc_clk/8, so all handshakes tolerate its slow, multi-cycle strobes.
// PARAMETERS
// N_REQ       4      number of requesters (2..8)
// GAP_CLKS    16     idle osc_clk cycles inserted after each byte's done edge
// ACT_TMO     64     max osc_clk cycles from DV assert to o_Tx_Active high before abort
// MAX_PKT     255    max bytes per lock; 0 = unlimited
// PORTS
// osc_clk          in   1        system clock
// i_Rst            in   1        synchronous, active-high reset
// i_Req_Valid      in   N_REQ    requester k has a byte on i_Req_Byte[8k+:8]
// i_Req_Byte       in   8*N_REQ  packed request bytes
// i_Req_Last       in   N_REQ    byte is last of packet; releases lock
// o_Req_Ready      out  N_REQ    one-cycle accept strobe to granted requester
// o_Grant          out  N_REQ    one-hot current owner; 0 when unlocked
// o_Tx_DV          out  1        to uart_tx i_Tx_DV
// o_Tx_Byte        out  8        to uart_tx i_Tx_Byte, registered
// i_Tx_Active      in   1        from uart_tx o_Tx_Active
// i_Tx_Done        in   1        from uart_tx o_Tx_Done (high ~16 osc_clk)
// o_Busy           out  1        state != IDLE or lock held
// o_Err_Tmo        out  1        one-cycle pulse on ACT_TMO abort
// BEHAVIOUR
// - Reset: all outputs 0, state IDLE, lock cleared, RR pointer = 0, counters 0. Reset mid-byte drops o_Tx_DV same edge; uart_tx not reset.
// - States: IDLE -> ARB -> LOAD -> WAIT_ACT -> WAIT_DONE -> GAP -> IDLE.
// - IDLE: if lock held and owner valid -> LOAD; if unlocked and any valid -> ARB; else stay.
// - ARB (1 cycle): rr_arbiter picks first valid at or after pointer+1 (mod N_REQ); sets o_Grant, lock=1 -> LOAD.
//   If valid dropped meanwhile: no grant -> IDLE.
// - LOAD: latch owner byte into o_Tx_Byte, pulse o_Req_Ready[owner] 1 cycle, capture last flag, o_Tx_DV<=1, clear tmo cnt -> WAIT_ACT.
// - WAIT_ACT: hold o_Tx_DV=1 until i_Tx_Active=1, then o_Tx_DV<=0 -> WAIT_DONE.
//   If tmo cnt reaches ACT_TMO-1 first: o_Tx_DV<=0, o_Err_Tmo pulse, lock released, -> IDLE.
// - WAIT_DONE: wait for rising edge of i_Tx_Done (registered previous sample); level alone is not accepted -> GAP.
// - GAP: count GAP_CLKS cycles (guarantees uart_tx back in IDLE before next DV).
//   At exit: if captured last=1 or pkt cnt==MAX_PKT-1 (MAX_PKT!=0): release lock, pointer<=owner, pkt cnt<=0. Else pkt cnt+1. -> IDLE.
// - Locked owner deasserting valid mid-packet: lock is held, no other grant (no timeout on requester side).
// - Byte latency: o_Req_Ready asserts 2 cycles after valid when unlocked, 1 cycle when locked.
// - o_Req_Ready never asserts for a non-owner; at most one bit set.
// - Requester must hold i_Req_Byte/i_Req_Last stable while valid until ready.
// - Counters: tmo 7 bit, gap 5 bit, pkt 8 bit; width from $clog2 of parameter+1. Saturation never reached by design.
// STRUCTURE
// - uart_sched_defs.vh: state encodings (3 bit), defaults for GAP_CLKS/ACT_TMO.
// - Sub-module rr_arbiter (N_REQ, req vector, pointer -> one-hot grant + valid), purely combinational; FSM/counters in top.
// - uart_tx instantiated by parent, not inside this block.
// TESTING (bench instantiates uart_tx CLKS_PER_BIT=4 on osc_clk)
// - Reset with valid high on req0 -> no DV, outputs 0 until i_Rst low; first grant goes to req1 if valid, else req0.
// - req0 sends 3-byte pkt 0x41,0x42,0x43(last) while req2 valid -> serial line shows 41,42,43 then req2's byte; no interleave.
// - req0..3 each single-byte last, all valid -> grants 1,2,3,0 in order; each ready strobe exactly 1 cycle.
// - Stub i_Tx_Active stuck 0 -> o_Tx_DV drops and o_Err_Tmo pulses after 64 cycles; lock released; next requester served.
// - MAX_PKT=2, req1 streams 5 bytes no last, req3 valid -> order r1,r1,r3,r1,r1,r3...
// - Assert i_Rst during WAIT_DONE -> DV 0, grant 0 next edge; after uart_tx finishes, new byte sent intact.

Source files
------------

// File: rtl/uart_tx_sched_pkg.sv
// Shared definitions for the uart_tx byte scheduler: FSM encodings,
// parameter defaults and a one-hot to index helper.
package uart_tx_sched_pkg;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE      = 3'd0;
    localparam state_t S_ARB       = 3'd1;
    localparam state_t S_LOAD      = 3'd2;
    localparam state_t S_WAIT_ACT  = 3'd3;
    localparam state_t S_WAIT_DONE = 3'd4;
    localparam state_t S_GAP       = 3'd5;

    localparam int DEF_N_REQ    = 4;
    localparam int DEF_GAP_CLKS = 16;
    localparam int DEF_ACT_TMO  = 64;
    localparam int DEF_MAX_PKT  = 255;

    function automatic logic [2:0] oh2idx(input logic [7:0] oh);
        logic [2:0] idx;
        idx = '0;
        for (int i = 0; i < 8; i++)
            if (oh[i]) idx = 3'(i);
        return idx;
    endfunction

endpackage

// File: rtl/uart_tx_sched_rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr+1
// (mod N_REQ), returned one-hot.
module uart_tx_sched_rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int PTR_W = $clog2(N_REQ)
)(
    input  logic [N_REQ-1:0] i_req,
    input  logic [PTR_W-1:0] i_ptr,
    output logic [N_REQ-1:0] o_grant,
    output logic             o_valid
);

    logic [PTR_W-1:0] w_start;
    logic [N_REQ-1:0] w_rot;
    logic [N_REQ-1:0] w_rot_gnt;

    assign w_start = (i_ptr == PTR_W'(N_REQ - 1)) ? '0 : i_ptr + PTR_W'(1);

    // Rotate so the search start sits at bit 0, isolate the lowest set bit,
    // then rotate the winner back into requester order.
    assign w_rot     = N_REQ'({i_req, i_req} >> w_start);
    assign w_rot_gnt = w_rot & (~w_rot + N_REQ'(1));
    assign o_grant   = N_REQ'(({w_rot_gnt, w_rot_gnt} << w_start) >> N_REQ);
    assign o_valid   = |i_req;

endmodule

// File: rtl/uart_tx_sched.sv
// Packet-locked round-robin scheduler feeding one shared uart_tx; paces each
// byte on the slow Active/Done strobes and aborts if Active never shows up.
module uart_tx_sched
    import uart_tx_sched_pkg::*;
#(
    parameter int N_REQ    = DEF_N_REQ,
    parameter int GAP_CLKS = DEF_GAP_CLKS,
    parameter int ACT_TMO  = DEF_ACT_TMO,
    parameter int MAX_PKT  = DEF_MAX_PKT
)(
    input  logic               osc_clk,
    input  logic               i_Rst,
    input  logic [N_REQ-1:0]   i_Req_Valid,
    input  logic [8*N_REQ-1:0] i_Req_Byte,
    input  logic [N_REQ-1:0]   i_Req_Last,
    output logic [N_REQ-1:0]   o_Req_Ready,
    output logic [N_REQ-1:0]   o_Grant,
    output logic               o_Tx_DV,
    output logic [7:0]         o_Tx_Byte,
    input  logic               i_Tx_Active,
    input  logic               i_Tx_Done,
    output logic               o_Busy,
    output logic               o_Err_Tmo
);

    localparam int PTR_W = $clog2(N_REQ);
    localparam int TMO_W = $clog2(ACT_TMO + 1);
    localparam int GAP_W = $clog2(GAP_CLKS + 1);
    localparam int PKT_W = (MAX_PKT > 0) ? $clog2(MAX_PKT + 1) : 1;

    state_t           r_state;
    logic [N_REQ-1:0] r_grant;
    logic [PTR_W-1:0] r_ptr;
    logic             r_tx_dv;
    logic [7:0]       r_tx_byte;
    logic             r_last;
    logic [TMO_W-1:0] r_tmo_cnt;
    logic [GAP_W-1:0] r_gap_cnt;
    logic [PKT_W-1:0] r_pkt_cnt;
    logic             r_done_q;
    logic             r_err_tmo;

    logic [N_REQ-1:0] w_arb_gnt;
    logic             w_arb_vld;
    logic [7:0]       w_own_byte;
    logic             w_own_valid;
    logic             w_own_last;
    logic [PTR_W-1:0] w_own_idx;
    logic             w_lock;
    logic             w_pkt_full;

    uart_tx_sched_rr_arbiter #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_rr_arbiter (
        .i_req   (i_Req_Valid),
        .i_ptr   (r_ptr),
        .o_grant (w_arb_gnt),
        .o_valid (w_arb_vld)
    );

    always_comb begin
        w_own_byte = '0;
        for (int k = 0; k < N_REQ; k++)
            if (r_grant[k]) w_own_byte = i_Req_Byte[8*k +: 8];
    end

    assign w_own_valid = |(i_Req_Valid & r_grant);
    assign w_own_last  = |(i_Req_Last & r_grant);
    assign w_own_idx   = PTR_W'(oh2idx(8'(r_grant)));
    assign w_lock      = |r_grant;
    assign w_pkt_full  = (MAX_PKT != 0) && (r_pkt_cnt == PKT_W'(MAX_PKT - 1));

    always_ff @(posedge osc_clk) begin
        if (i_Rst) begin
            r_state   <= S_IDLE;
            r_grant   <= '0;
            r_ptr     <= '0;
            r_tx_dv   <= 1'b0;
            r_tx_byte <= '0;
            r_last    <= 1'b0;
            r_tmo_cnt <= '0;
            r_gap_cnt <= '0;
            r_pkt_cnt <= '0;
            r_done_q  <= 1'b0;
            r_err_tmo <= 1'b0;
        end else begin
            r_done_q  <= i_Tx_Done;
            r_err_tmo <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_lock) begin
                        if (w_own_valid) r_state <= S_LOAD;
                    end else if (|i_Req_Valid) begin
                        r_state <= S_ARB;
                    end
                end
                S_ARB: begin
                    if (w_arb_vld) begin
                        r_grant <= w_arb_gnt;
                        r_state <= S_LOAD;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_LOAD: begin
                    r_tx_byte <= w_own_byte;
                    r_last    <= w_own_last;
                    r_tx_dv   <= 1'b1;
                    r_tmo_cnt <= '0;
                    r_state   <= S_WAIT_ACT;
                end
                S_WAIT_ACT: begin
                    if (i_Tx_Active) begin
                        r_tx_dv <= 1'b0;
                        r_state <= S_WAIT_DONE;
                    end else if (r_tmo_cnt == TMO_W'(ACT_TMO - 1)) begin
                        // Abort drops the lock and moves the pointer past the stuck owner.
                        r_tx_dv   <= 1'b0;
                        r_err_tmo <= 1'b1;
                        r_grant   <= '0;
                        r_ptr     <= w_own_idx;
                        r_pkt_cnt <= '0;
                        r_state   <= S_IDLE;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
                    end
                end
                S_WAIT_DONE: begin
                    // Done is held high for many cycles; only its rising edge ends the byte.
                    if (i_Tx_Done && !r_done_q) begin
                        r_gap_cnt <= '0;
                        r_state   <= S_GAP;
                    end
                end
                S_GAP: begin
                    if (r_gap_cnt == GAP_W'(GAP_CLKS - 1)) begin
                        if (r_last || w_pkt_full) begin
                            r_grant   <= '0;
                            r_ptr     <= w_own_idx;
                            r_pkt_cnt <= '0;
                        end else begin
                            r_pkt_cnt <= r_pkt_cnt + PKT_W'(1);
                        end
                        r_state <= S_IDLE;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + GAP_W'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_Req_Ready = (r_state == S_LOAD) ? r_grant : '0;
    assign o_Grant     = r_grant;
    assign o_Tx_DV     = r_tx_dv;
    assign o_Tx_Byte   = r_tx_byte;
    assign o_Busy      = (r_state != S_IDLE) || w_lock;
    assign o_Err_Tmo   = r_err_tmo;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Scoreboard bench for uart_tx_sched with a behavioural uart_tx
// (CLKS_PER_BIT=4 frame timing) and per-requester byte queues.
module tb_uart_tx_sched;

    localparam int N          = 4;
    localparam int TB_MAX_PKT = 3;
    localparam int FRAME_CLKS = 40;
    localparam int DONE_CLKS  = 8;

    logic             osc_clk     = 1'b0;
    logic             i_Rst       = 1'b1;
    logic [N-1:0]     i_Req_Valid = '0;
    logic [8*N-1:0]   i_Req_Byte  = '0;
    logic [N-1:0]     i_Req_Last  = '0;
    logic [N-1:0]     o_Req_Ready;
    logic [N-1:0]     o_Grant;
    logic             o_Tx_DV;
    logic [7:0]       o_Tx_Byte;
    logic             o_Busy;
    logic             o_Err_Tmo;

    logic             m_act   = 1'b0;
    logic             m_done  = 1'b0;
    logic             m_stuck = 1'b0;
    logic [1:0]       m_st    = 2'd0;
    logic [7:0]       m_byte  = 8'h00;
    int               m_cnt   = 0;

    int               n_tests = 0;
    int               n_fail  = 0;
    int               n_err   = 0;
    int               cyc     = 0;

    logic [8:0]       rq [N][$];
    logic [11:0]      exp_rq[$];
    logic [7:0]       exp_line[$];

    always #5 osc_clk = ~osc_clk;

    uart_tx_sched #(
        .N_REQ    (N),
        .GAP_CLKS (16),
        .ACT_TMO  (64),
        .MAX_PKT  (TB_MAX_PKT)
    ) dut (
        .osc_clk     (osc_clk),
        .i_Rst       (i_Rst),
        .i_Req_Valid (i_Req_Valid),
        .i_Req_Byte  (i_Req_Byte),
        .i_Req_Last  (i_Req_Last),
        .o_Req_Ready (o_Req_Ready),
        .o_Grant     (o_Grant),
        .o_Tx_DV     (o_Tx_DV),
        .o_Tx_Byte   (o_Tx_Byte),
        .i_Tx_Active (m_act),
        .i_Tx_Done   (m_done),
        .o_Busy      (o_Busy),
        .o_Err_Tmo   (o_Err_Tmo)
    );

    // Behavioural uart_tx: not touched by i_Rst, ignores DV while stuck.
    always @(posedge osc_clk) begin
        case (m_st)
            2'd0: if (o_Tx_DV && !m_stuck) begin
                m_st <= 2'd1; m_act <= 1'b1; m_byte <= o_Tx_Byte; m_cnt <= 0;
            end
            2'd1: if (m_cnt == FRAME_CLKS - 1) begin
                m_st <= 2'd2; m_act <= 1'b0; m_done <= 1'b1; m_cnt <= 0;
            end else m_cnt <= m_cnt + 1;
            default: if (m_cnt == DONE_CLKS - 1) begin
                m_st <= 2'd0; m_done <= 1'b0;
            end else m_cnt <= m_cnt + 1;
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic send(input int k, input logic [7:0] b, input logic last, input logic on_line);
        rq[k].push_back({last, b});
        exp_rq.push_back({4'(k), b});
        if (on_line) exp_line.push_back(b);
    endtask

    function automatic bit rq_busy();
        for (int k = 0; k < N; k++)
            if (rq[k].size() != 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        repeat (3) @(negedge osc_clk);
        while ((rq_busy() || o_Busy || m_st != 2'd0) && n < 3000) begin
            @(negedge osc_clk);
            n++;
        end
        chk(name, 32'(n < 3000), 1);
        repeat (30) @(negedge osc_clk);
    endtask

    // Requesters: a byte counts as taken on the edge after its ready strobe.
    initial begin : driver
        logic [N-1:0] acc;
        logic [8:0]   f;
        forever begin
            @(negedge osc_clk);
            acc = o_Req_Ready;
            @(posedge osc_clk);
            #1;
            for (int k = 0; k < N; k++) begin
                if (acc[k] && rq[k].size() > 0) void'(rq[k].pop_front());
                f = (rq[k].size() > 0) ? rq[k][0] : 9'h000;
                i_Req_Valid[k]       = rq[k].size() > 0;
                i_Req_Byte[8*k +: 8] = f[7:0];
                i_Req_Last[k]        = f[8];
            end
        end
    end

    initial begin : monitor
        logic [N-1:0] prev_rdy;
        logic [N-1:0] grant_at_done;
        logic         prev_dv, prev_act, prev_done, prev_err;
        int           last_done_cyc, id;
        prev_rdy = '0; grant_at_done = '0;
        prev_dv = 1'b0; prev_act = 1'b0; prev_done = 1'b0; prev_err = 1'b0;
        last_done_cyc = -1000;
        forever begin
            @(negedge osc_clk);
            cyc++;
            if (o_Err_Tmo && !prev_err) n_err++;
            if (o_Req_Ready != '0) begin
                chk("ready_is_owner", 32'((o_Req_Ready == o_Grant) && $onehot(o_Req_Ready)), 1);
                chk("ready_one_cycle", 32'(prev_rdy), 0);
                id = 0;
                for (int k = 0; k < N; k++)
                    if (o_Req_Ready[k]) id = k;
                if (exp_rq.size() == 0)
                    chk("ready_unexpected", exp_rq.size(), 1);
                else
                    chk("ready_req_id_byte", {id[3:0], i_Req_Byte[8*id +: 8]}, 32'(exp_rq.pop_front()));
            end
            if (m_act && !prev_act) begin
                if (exp_line.size() == 0)
                    chk("line_unexpected", exp_line.size(), 1);
                else
                    chk("line_byte", 32'(m_byte), 32'(exp_line.pop_front()));
            end
            if (m_done && !prev_done) begin
                last_done_cyc = cyc;
                grant_at_done = o_Grant;
            end
            // Done rise -> 1 detect + 16 gap + IDLE -> (ARB) -> LOAD -> DV.
            if (o_Tx_DV && !prev_dv && grant_at_done != '0 && (cyc - last_done_cyc) <= 40)
                chk("gap_done_to_dv", cyc - last_done_cyc, (o_Grant == grant_at_done) ? 19 : 20);
            prev_rdy = o_Req_Ready; prev_dv = o_Tx_DV; prev_act = m_act;
            prev_done = m_done; prev_err = o_Err_Tmo;
        end
    end

    initial begin : stim
        int n;
        // Reset held with req0 valid: nothing leaves, then req0 wins (req1 idle).
        send(0, 8'h10, 1'b1, 1'b1);
        repeat (2) @(posedge osc_clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge osc_clk);
            chk("reset_outputs_zero",
                32'({o_Tx_DV, o_Grant, o_Req_Ready, o_Busy, o_Err_Tmo, o_Tx_Byte}), 0);
        end
        i_Rst = 1'b0;
        n = 0;
        do begin
            @(negedge osc_clk);
            n++;
        end while (o_Req_Ready == '0 && n < 20);
        chk("unlocked_ready_latency", n, 2);
        wait_idle("t1_idle");

        // All four valid, single-byte packets, pointer at 0 -> 1,2,3,0.
        send(1, 8'hC1, 1'b1, 1'b1);
        send(2, 8'hC2, 1'b1, 1'b1);
        send(3, 8'hC3, 1'b1, 1'b1);
        send(0, 8'hC0, 1'b1, 1'b1);
        wait_idle("t3_idle");

        // req0 3-byte packet locks out req2 until the last byte.
        send(0, 8'h41, 1'b0, 1'b1);
        send(0, 8'h42, 1'b0, 1'b1);
        send(0, 8'h43, 1'b1, 1'b1);
        n = 0;
        while (o_Grant != 4'b0001 && n < 50) begin
            @(negedge osc_clk);
            n++;
        end
        chk("t2_req0_locked", 32'(o_Grant), 32'h1);
        send(2, 8'h55, 1'b1, 1'b1);
        wait_idle("t2_idle");

        // Active stuck low: req3 (pointer 2) times out, then req0 is served.
        m_stuck = 1'b1;
        send(3, 8'h77, 1'b1, 1'b0);
        send(0, 8'h66, 1'b1, 1'b1);
        n = 0;
        while (!o_Tx_DV && n < 20) begin
            @(negedge osc_clk);
            n++;
        end
        chk("tmo_dv_seen", 32'(o_Tx_DV), 1);
        n = 0;
        while (o_Tx_DV && n < 200) begin
            @(negedge osc_clk);
            n++;
        end
        chk("tmo_dv_high_cycles", n, 64);
        chk("tmo_err_pulse", 32'(o_Err_Tmo), 1);
        chk("tmo_lock_released", 32'(o_Grant), 0);
        m_stuck = 1'b0;
        @(negedge osc_clk);
        chk("tmo_err_one_cycle", 32'(o_Err_Tmo), 0);
        wait_idle("t4_idle");

        // Packet cap of 3: req1 streams 5 bytes, req3 slips in after the 3rd.
        send(1, 8'hA1, 1'b0, 1'b1);
        send(1, 8'hA2, 1'b0, 1'b1);
        send(1, 8'hA3, 1'b0, 1'b1);
        send(3, 8'hB3, 1'b1, 1'b1);
        send(1, 8'hA4, 1'b0, 1'b1);
        send(1, 8'hA5, 1'b1, 1'b1);
        wait_idle("t5_idle");

        // Reset while waiting for Done: the in-flight byte still completes.
        send(2, 8'h5A, 1'b1, 1'b1);
        n = 0;
        while (!m_act && n < 40) begin
            @(negedge osc_clk);
            n++;
        end
        chk("t6_active_seen", 32'(m_act), 1);
        repeat (5) @(negedge osc_clk);
        chk("t6_grant_before_reset", 32'(o_Grant), 32'h4);
        i_Rst = 1'b1;
        @(negedge osc_clk);
        chk("t6_reset_grant", 32'(o_Grant), 0);
        chk("t6_reset_dv_busy", 32'({o_Tx_DV, o_Busy}), 0);
        i_Rst = 1'b0;
        n = 0;
        while (m_st != 2'd0 && n < 100) begin
            @(negedge osc_clk);
            n++;
        end
        chk("t6_uart_finished", 32'(m_st), 0);
        send(3, 8'h3C, 1'b1, 1'b1);
        wait_idle("t6_idle");

        chk("exp_ready_drained", exp_rq.size(), 0);
        chk("exp_line_drained", exp_line.size(), 0);
        chk("tmo_pulse_count", n_err, 1);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: run did not complete, %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1);
    end

endmodule
